oper_order_fsm: RTL and testbench



---
 rtl/oper_order_fsm.sv | 102 ++++++++++
 tb/tb_oper_order_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/oper_order_fsm.sv
// Operand-ordering unit for the FPU add/subtract path: latches X/Y/op, orders
// the operands by magnitude and resolves effective op, result sign and cancellation.
module oper_order_fsm #(
  parameter int unsigned W = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W:0]   Data_X_i,
  input  logic [W:0]   Data_Y_i,
  input  logic         add_subt_i,
  input  logic         ack_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic         swap_o,
  output logic [W:0]   DMP_o,
  output logic [W:0]   DmP_o,
  output logic         real_op_o,
  output logic         sign_final_o,
  output logic         zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [W:0] x_q;
  logic [W:0] y_q;
  logic       op_q;

  logic       swap_c;
  logic       eq_c;
  logic       real_op_c;
  logic       sign_c;

  // Magnitude ordering on raw bit patterns; ties favour X as the larger operand.
  always_comb begin
    swap_c    = (x_q[W-1:0] >= y_q[W-1:0]);
    eq_c      = (x_q[W-1:0] == y_q[W-1:0]);
    real_op_c = op_q ^ x_q[W] ^ y_q[W];
    sign_c    = swap_c ? x_q[W] : (y_q[W] ^ op_q);
    if (eq_c && real_op_c) begin
      sign_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= 1'b0;
      busy_o       <= 1'b0;
      ready_o      <= 1'b0;
      swap_o       <= 1'b0;
      DMP_o        <= '0;
      DmP_o        <= '0;
      real_op_o    <= 1'b0;
      sign_final_o <= 1'b0;
      zero_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            x_q    <= Data_X_i;
            y_q    <= Data_Y_i;
            op_q   <= add_subt_i;
            busy_o <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          swap_o       <= swap_c;
          DMP_o        <= swap_c ? x_q : y_q;
          DmP_o        <= swap_c ? y_q : x_q;
          real_op_o    <= real_op_c;
          sign_final_o <= sign_c;
          zero_o       <= eq_c & real_op_c;
          ready_o      <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          // Results stay on the outputs after the handshake; only the flags drop.
          if (ack_i) begin
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oper_order_fsm.sv
// Directed bench for oper_order_fsm: vector table plus handshake and reset sequences.
module tb_oper_order_fsm;

  localparam int unsigned W = 31;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_i;
  logic [W:0]   Data_X_i;
  logic [W:0]   Data_Y_i;
  logic         add_subt_i;
  logic         ack_i;
  logic         busy_o;
  logic         ready_o;
  logic         swap_o;
  logic [W:0]   DMP_o;
  logic [W:0]   DmP_o;
  logic         real_op_o;
  logic         sign_final_o;
  logic         zero_o;

  int tests = 0;
  int fails = 0;

  oper_order_fsm #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .Data_X_i     (Data_X_i),
    .Data_Y_i     (Data_Y_i),
    .add_subt_i   (add_subt_i),
    .ack_i        (ack_i),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .swap_o       (swap_o),
    .DMP_o        (DMP_o),
    .DmP_o        (DmP_o),
    .real_op_o    (real_op_o),
    .sign_final_o (sign_final_o),
    .zero_o       (zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] x;
    logic [W:0] y;
    logic       op;
    logic       swap;
    logic [W:0] dmp;
    logic [W:0] dmp_s;
    logic       real_op;
    logic       sign;
    logic       zero;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_ready"}, 32'(ready_o), 32'd0);
    chk({tag, "_swap"},  32'(swap_o), 32'd0);
    chk({tag, "_DMP"},   32'(DMP_o), 32'd0);
    chk({tag, "_DmP"},   32'(DmP_o), 32'd0);
    chk({tag, "_real"},  32'(real_op_o), 32'd0);
    chk({tag, "_sign"},  32'(sign_final_o), 32'd0);
    chk({tag, "_zero"},  32'(zero_o), 32'd0);
  endtask

  task automatic chk_results(input vec_t v, input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_busy"},  32'(busy_o), 32'd1);
    chk({tag, "_swap"},  32'(swap_o), 32'(v.swap));
    chk({tag, "_DMP"},   32'(DMP_o), 32'(v.dmp));
    chk({tag, "_DmP"},   32'(DmP_o), 32'(v.dmp_s));
    chk({tag, "_real"},  32'(real_op_o), 32'(v.real_op));
    chk({tag, "_sign"},  32'(sign_final_o), 32'(v.sign));
    chk({tag, "_zero"},  32'(zero_o), 32'(v.zero));
  endtask

  // Load at one edge, check latency, results, then acknowledge.
  task automatic run_op(input vec_t v, input string tag);
    load_i = 1'b1; Data_X_i = v.x; Data_Y_i = v.y; add_subt_i = v.op;
    step();
    chk({tag, "_cmp_busy"},  32'(busy_o), 32'd1);
    chk({tag, "_cmp_ready"}, 32'(ready_o), 32'd0);
    load_i = 1'b0;
    step();
    chk_results(v, tag);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk({tag, "_ack_ready"}, 32'(ready_o), 32'd0);
    chk({tag, "_ack_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_ack_DMP"},   32'(DMP_o), 32'(v.dmp));
  endtask

  initial begin
    vec_t h;
    vecs[0] = '{32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40400000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'h40400000, 32'h3F800000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'hC0000000, 32'h40000000, 1'b0, 1'b1, 32'hC0000000, 32'h40000000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'hC0000000, 32'h40000000, 1'b1, 1'b1, 32'hC0000000, 32'h40000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h40000000, 32'h40000000, 1'b1, 1'b1, 32'h40000000, 32'h40000000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'hC0400000, 32'h3F800000, 1'b1, 1'b1, 32'hC0400000, 32'h3F800000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h00000001, 32'h80000002, 1'b0, 1'b0, 32'h80000002, 32'h00000001, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h7FC00000, 32'hFF800000, 1'b0, 1'b1, 32'h7FC00000, 32'hFF800000, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; load_i = 1'b1; ack_i = 1'b1;
    Data_X_i = 32'h40400000; Data_Y_i = 32'h3F800000; add_subt_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_all_zero("reset");
    step();
    chk_all_zero("reset_hold");
    rst_n = 1'b1; load_i = 1'b0; ack_i = 1'b0;
    step();
    chk("idle_busy", 32'(busy_o), 32'd0);

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Handshake: results hold while ack is low and load is ignored in DONE.
    h = vecs[0];
    load_i = 1'b1; Data_X_i = h.x; Data_Y_i = h.y; add_subt_i = h.op;
    step();
    Data_X_i = 32'h00000005; Data_Y_i = 32'h7F000000; add_subt_i = 1'b1;
    step();
    chk_results(h, "hs_done");
    for (int i = 0; i < 5; i++) begin
      Data_X_i = 32'(i + 7); Data_Y_i = 32'hC1000000 + 32'(i);
      step();
      chk_results(h, $sformatf("hs_hold%0d", i));
    end
    ack_i = 1'b1; load_i = 1'b1;
    Data_X_i = vecs[1].x; Data_Y_i = vecs[1].y; add_subt_i = vecs[1].op;
    step();
    ack_i = 1'b0;
    chk("hs_ack_ready", 32'(ready_o), 32'd0);
    chk("hs_ack_busy",  32'(busy_o), 32'd0);
    chk("hs_ack_DMP",   32'(DMP_o), 32'(h.dmp));
    step();
    chk("hs_reload_busy",  32'(busy_o), 32'd1);
    chk("hs_reload_ready", 32'(ready_o), 32'd0);
    load_i = 1'b0;
    step();
    chk_results(vecs[1], "hs_reload");
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;

    // Reset sampled while in CMP.
    load_i = 1'b1; Data_X_i = vecs[2].x; Data_Y_i = vecs[2].y; add_subt_i = vecs[2].op;
    step();
    load_i = 1'b0;
    chk("rcmp_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("rst_cmp");
    step();
    chk_all_zero("rst_cmp_idle");

    // Reset sampled while in DONE.
    load_i = 1'b1; Data_X_i = vecs[2].x; Data_Y_i = vecs[2].y; add_subt_i = vecs[2].op;
    step();
    load_i = 1'b0;
    step();
    chk_results(vecs[2], "rdone_pre");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("rst_done");

    run_op(vecs[6], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
